// File: rtl/opcodes_pkg.sv
// Shared CPU-side typedefs. The program loader adds its FSM state encodings here
// so the top level and any debug tooling see one definition.
package opcodes;

  // Program loader frame-level states
  typedef enum logic [2:0] {
    LEN,
    DATA,
    CHECK,
    DONE,
    ERR
  } loader_state_t;

  // Serial receiver bit-level states
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // A serial byte is always 8 bits regardless of the CPU word width
  localparam int unsigned UART_BITS = 8;

endpackage : opcodes

// File: rtl/prog_loader_uart_rx.sv
// 8N1 serial receiver, LSB first. Rx is synchronised, a start edge is confirmed
// at half a bit, then data and stop bits are sampled at mid-bit. A good stop bit
// gives a one-cycle ByteValid, a bad one a one-cycle FrameErr.
module uart_rx
  import opcodes::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       Rx,
  output logic       ByteValid,
  output logic [7:0] ByteData,
  output logic       FrameErr
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  logic            rx_meta_q, rx_sync_q;
  rx_state_t       state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            valid_q, ferr_q;

  // Two-flop synchroniser; resets to the idle-high line level
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so both flops sample the old values and
      // the chain really is two stages deep.
      rx_meta_q <= Rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Bit-timing FSM: start confirmation, 8 data bits, stop bit
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle so each event is a single pulse.
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      unique case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (!rx_sync_q) state_q <= RX_START;
        end
        RX_START: begin
          if (cnt_q == CW'(HALF - 1)) begin
            cnt_q <= '0;
            if (rx_sync_q) begin
              state_q <= RX_IDLE;           // glitch, not a start bit
            end else begin
              state_q   <= RX_DATA;
              bit_idx_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) state_q <= RX_STOP;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (rx_sync_q) valid_q <= 1'b1;
            else           ferr_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign ByteValid = valid_q;
  assign ByteData  = shift_q;
  assign FrameErr  = ferr_q;

endmodule : uart_rx

// File: rtl/prog_loader.sv
// Serial program loader: receives [L][L data bytes][checksum] and writes the
// data into program RAM from address 0, releasing the CPU only after the
// checksum matches. DONE and ERR are terminal until nReset.
module prog_loader
  import opcodes::*;
#(
  parameter int n            = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic         Clock,
  input  logic         nReset,
  input  logic         Rx,
  output logic         WrEn,
  output logic [n-1:0] WrAddr,
  output logic [n-1:0] WrData,
  output logic         CpuRun,
  output logic         Busy,
  output logic         Error
);

  logic                 byte_valid, frame_err;
  logic [UART_BITS-1:0] byte_data;
  logic [n-1:0]         rx_byte;

  loader_state_t state_q;
  logic [n:0]    count_q;      // one extra bit so a 2^n-byte image fits
  logic [n-1:0]  sum_q, addr_q;
  logic          wr_en_q, cpu_run_q, busy_q, error_q;
  logic [n-1:0]  wr_addr_q, wr_data_q;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .Clock    (Clock),
    .nReset   (nReset),
    .Rx       (Rx),
    .ByteValid(byte_valid),
    .ByteData (byte_data),
    .FrameErr (frame_err)
  );

  assign rx_byte = n'(byte_data);

  // Frame FSM with registered write port and status outputs
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= LEN;
      count_q   <= '0;
      sum_q     <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cpu_run_q <= 1'b0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        LEN: begin
          if (frame_err) begin
            state_q <= ERR;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else if (byte_valid) begin
            count_q <= (rx_byte == '0) ? {1'b1, {n{1'b0}}} : {1'b0, rx_byte};
            sum_q   <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (frame_err) begin
            state_q <= ERR;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else if (byte_valid) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= rx_byte;
            sum_q     <= sum_q + rx_byte;
            addr_q    <= addr_q + n'(1);   // wraps after 2^n-1, never written
            count_q   <= count_q - (n+1)'(1);
            if (count_q == (n+1)'(1)) state_q <= CHECK;
          end
        end
        CHECK: begin
          if (frame_err) begin
            state_q <= ERR;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else if (byte_valid) begin
            busy_q <= 1'b0;
            if (rx_byte == sum_q) begin
              state_q   <= DONE;
              cpu_run_q <= 1'b1;
            end else begin
              state_q <= ERR;
              error_q <= 1'b1;
            end
          end
        end
        DONE, ERR: ;                  // terminal until nReset
        default: state_q <= ERR;
      endcase
    end
  end

  assign WrEn   = wr_en_q;
  assign WrAddr = wr_addr_q;
  assign WrData = wr_data_q;
  assign CpuRun = cpu_run_q;
  assign Busy   = busy_q;
  assign Error  = error_q;

endmodule : prog_loader
